// File: rtl/rv32i_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional illegal-instruction trap state enabled by defining RV32I_ILLEGAL_TRAP_EN.
module rv32i_multicycle_ctrl #(
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic [2:0]  imm_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic [1:0]  alu_op,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        instret,
  output logic        trap
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // The datapath muxes TRAP_VEC in on pc_sel=3; it must be a legal fetch address.
  generate
    if (TRAP_VEC[1:0] != 2'b00) begin : g_bad_trap_vec
      $error("TRAP_VEC must be word aligned");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    DECODE = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    WB     = 3'd5
`ifdef RV32I_ILLEGAL_TRAP_EN
    ,TRAP  = 3'd6
`endif
  } state_t;

  state_t     state, state_nxt;
  logic [6:0] opcode;
  logic [2:0] imm_dec;
  logic       a_dec, b_dec;
  logic [1:0] op_dec;
  logic       unused_inst_bits;

  assign unused_inst_bits = ^inst[31:7];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      opcode <= 7'd0;
    end else begin
      state <= state_nxt;
      if (state == FETCH && imem_ack) opcode <= inst[6:0];
    end
  end

  // Opcode-only decodes; reused by every state after DECODE so selects stay stable.
  always_comb begin
    imm_dec = 3'd0;
    a_dec   = 1'b0;
    b_dec   = 1'b0;
    op_dec  = 2'd0;
    case (opcode)
      OP_STORE:           imm_dec = 3'd1;
      OP_BRANCH:          imm_dec = 3'd2;
      OP_LUI, OP_AUIPC:   imm_dec = 3'd3;
      OP_JAL:             imm_dec = 3'd4;
      default:            imm_dec = 3'd0;
    endcase
    case (opcode)
      OP_OP:                       op_dec = 2'd1;
      OP_OPIMM:                    begin b_dec = 1'b1; op_dec = 2'd2; end
      OP_LOAD, OP_STORE, OP_JALR:  b_dec = 1'b1;
      OP_AUIPC:                    begin a_dec = 1'b1; b_dec = 1'b1; end
      OP_BRANCH:                   op_dec = 2'd3;
      default:                     op_dec = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = 2'd0;
    imm_sel   = 3'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    alu_op    = 2'd0;
    reg_we    = 1'b0;
    wb_sel    = 2'd0;
    instret   = 1'b0;
    trap      = 1'b0;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we     = 1'b1;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
        imm_sel   = imm_dec;
        state_nxt = EXEC;
      end
      EXEC: begin
        imm_sel   = imm_dec;
        alu_a_sel = a_dec;
        alu_b_sel = b_dec;
        alu_op    = op_dec;
        case (opcode)
          OP_OP, OP_OPIMM, OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: state_nxt = WB;
          OP_LOAD, OP_STORE: state_nxt = MEM;
          OP_BRANCH: begin
            pc_we     = 1'b1;
            pc_sel    = {1'b0, br_taken};
            instret   = 1'b1;
            state_nxt = FETCH;
          end
          OP_FENCE, OP_SYSTEM: begin
            pc_we     = 1'b1;
            instret   = 1'b1;
            state_nxt = FETCH;
          end
          default: begin
`ifdef RV32I_ILLEGAL_TRAP_EN
            state_nxt = TRAP;
`else
            pc_we     = 1'b1;
            instret   = 1'b1;
            state_nxt = FETCH;
`endif
          end
        endcase
      end
      MEM: begin
        imm_sel   = imm_dec;
        alu_a_sel = a_dec;
        alu_b_sel = b_dec;
        alu_op    = op_dec;
        dmem_req  = 1'b1;
        dmem_we   = (opcode == OP_STORE);
        if (dmem_ack) begin
          if (opcode == OP_STORE) begin
            pc_we     = 1'b1;
            instret   = 1'b1;
            state_nxt = FETCH;
          end else begin
            state_nxt = WB;
          end
        end
      end
      WB: begin
        imm_sel   = imm_dec;
        alu_a_sel = a_dec;
        alu_b_sel = b_dec;
        alu_op    = op_dec;
        reg_we    = 1'b1;
        pc_we     = 1'b1;
        instret   = 1'b1;
        case (opcode)
          OP_LOAD:          wb_sel = 2'd1;
          OP_JAL, OP_JALR:  wb_sel = 2'd2;
          OP_LUI:           wb_sel = 2'd3;
          default:          wb_sel = 2'd0;
        endcase
        case (opcode)
          OP_JAL:   pc_sel = 2'd1;
          OP_JALR:  pc_sel = 2'd2;
          default:  pc_sel = 2'd0;
        endcase
        state_nxt = FETCH;
      end
`ifdef RV32I_ILLEGAL_TRAP_EN
      TRAP: begin
        imm_sel   = imm_dec;
        trap      = 1'b1;
        pc_we     = 1'b1;
        pc_sel    = 2'd3;
        state_nxt = FETCH;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: doc/rv32i_multicycle_ctrl.md
Name: rv32i_multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core.
- Sequences every instruction through fetch, decode, execute, memory and writeback.
- Drives the immediate-format select, ALU operand and operation selects, PC update, register-file write and the instruction/data memory handshakes.
- Sits between the instruction/data memory ports and the shared single-ALU datapath.

Parameters:
TRAP_VEC, 32'h0000_0100, PC target driven on illegal instruction (used only with the optional feature)

Ports:
clk  input  1  core clock, rising edge
rst_n  input  1  asynchronous active-low reset
inst  input  32  instruction word from imem, valid when imem_ack=1
imem_ack  input  1  imem accepts the request and returns inst in the same cycle
dmem_ack  input  1  dmem completes the request (load data valid in the same cycle)
br_taken  input  1  branch comparison result from the ALU, valid in EXEC
imem_req  output  1  instruction fetch request
dmem_req  output  1  data memory request
dmem_we  output  1  1=store, 0=load; valid while dmem_req=1
ir_we  output  1  capture inst into the datapath IR
pc_we  output  1  update the PC
pc_sel  output  2  0 pc+4, 1 pc+imm, 2 alu_result (JALR; datapath clears bit0), 3 TRAP_VEC
imm_sel  output  3  0 I, 1 S, 2 SB, 3 U, 4 UJ
alu_a_sel  output  1  0 rs1, 1 pc
alu_b_sel  output  1  0 rs2, 1 imm
alu_op  output  2  0 add, 1 funct3/funct7 R-type, 2 funct3 I-type, 3 branch compare
reg_we  output  1  register-file write enable
wb_sel  output  2  0 alu, 1 mem, 2 pc+4, 3 imm
instret  output  1  one-cycle pulse per retired instruction
trap  output  1  illegal-instruction indicator (optional feature)

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP. Reset state is IDLE.
- All outputs are combinational decodes of the state and the internally latched opcode, so every output is 0 while rst_n=0 and in IDLE.
- IDLE -> FETCH unconditionally on the next clock after reset release.
- FETCH:
  - imem_req=1 and is held until imem_ack.
  - On imem_ack: ir_we=1, inst[6:0] is latched into an internal opcode register, go to DECODE.
  - Without imem_ack: stay in FETCH.
- DECODE: one cycle, no side effects. imm_sel is driven from the latched opcode here and held through retire.
- imm_sel by opcode:
  - LOAD/OP-IMM/JALR: I
  - STORE: S
  - BRANCH: SB
  - LUI/AUIPC: U
  - JAL: UJ
  - all others: I
- EXEC by opcode:
  - OP: a=rs1, b=rs2, alu_op=1 -> WB.
  - OP-IMM: a=rs1, b=imm, alu_op=2 -> WB.
  - LOAD/STORE: a=rs1, b=imm, alu_op=0 (address) -> MEM.
  - AUIPC: a=pc, b=imm, alu_op=0 -> WB.
  - LUI: -> WB.
  - JAL: -> WB.
  - JALR: a=rs1, b=imm, alu_op=0 -> WB.
  - BRANCH: a=rs1, b=rs2, alu_op=3; pc_we=1, pc_sel = br_taken ? 1 : 0, instret=1 -> FETCH.
  - FENCE/SYSTEM: NOP; pc_we=1, pc_sel=0, instret=1 -> FETCH.
- MEM:
  - dmem_req=1 and is held until dmem_ack. dmem_we=1 for STORE.
  - Operand selects stay as in EXEC so the address is held stable.
  - STORE on ack: pc_we=1, pc_sel=0, instret=1 -> FETCH.
  - LOAD on ack: -> WB.
- WB: reg_we=1, pc_we=1, instret=1, then -> FETCH.
  - wb_sel: LOAD=1, JAL/JALR=2, LUI=3, otherwise 0.
  - pc_sel: JAL=1, JALR=2 (operands held as in EXEC), otherwise 0.
- Latency with zero-wait memories:
  - BRANCH/FENCE/SYSTEM: 3 cycles.
  - ALU/LUI/AUIPC/JAL/JALR: 4 cycles.
  - STORE: 4 cycles.
  - LOAD: 5 cycles.
  - Each memory wait cycle adds 1.
- Illegal instruction: inst[1:0] != 2'b11, or opcode not in the RV32I base set.
  - Without the optional feature it is handled as a NOP (retired in EXEC with pc_sel=0).
- Reset asserted mid-operation: immediate return to IDLE; any outstanding imem/dmem request is dropped. Memories must tolerate an abandoned request.
- Only one of imem_req/dmem_req is ever asserted in a given cycle.
- pc_we and reg_we are never asserted outside their retire cycle.

Optional Feature:
- Macro RV32I_ILLEGAL_TRAP_EN.
- When defined: an illegal opcode in EXEC goes to TRAP for one cycle with trap=1, pc_we=1, pc_sel=3, instret=0, then -> FETCH.
- When undefined: the TRAP state is absent, trap is tied to 0 and illegal opcodes retire as NOP.

Test Plan:
- Reset release, imem_ack tied 1, inst=ADDI x1,x0,5 (0x00500093):
  - imem_req rises 1 cycle after release.
  - ir_we in FETCH; imm_sel=0, alu_b_sel=1, alu_op=2 in EXEC.
  - reg_we/pc_we/instret in WB, 4 cycles per instruction.
- LW with dmem_ack delayed 3 cycles:
  - dmem_req held for 4 cycles with dmem_we=0.
  - Then WB with wb_sel=1, reg_we=1; total 8 cycles.
- SW 0x00112223: imm_sel=1; dmem_we=1; retire on the dmem_ack cycle with reg_we never asserted.
- BEQ:
  - br_taken=1: pc_sel=1, imm_sel=2, 3 cycles.
  - br_taken=0: pc_sel=0.
  - reg_we=0 in both cases.
- JAL 0x008000EF, then JALR 0x000080E7:
  - JAL: imm_sel=4, wb_sel=2, pc_sel=1.
  - JALR: imm_sel=0, pc_sel=2.
- inst=0xFFFFFFFF, then rst_n pulsed low mid-MEM of a LW:
  - With the macro: trap=1, pc_sel=3, instret=0. Without the macro: NOP retire.
  - Reset clears all outputs asynchronously; the FSM restarts at IDLE.
